pipe_mips32: RTL and testbench
==============================

Name: pipe_mips32

Overview:
- Five-stage in-order pipelined MIPS32 subset processor: IF, ID, EX, MEM, WB.
- Single unified word-addressed memory for instructions and data, plus a 32x32 register file.
- Standalone core: memory and registers are preloaded hierarchically by the environment; the core runs until a HLT instruction retires.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the internal array `memory`.
- NUM_REGS, 32, number of 32-bit registers in the internal array `register`.

Ports:
- clk1  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous reset, active-high.
- halted  output  1  High once HLT has retired; sticky until reset.

Behaviour:
- Internal arrays are named exactly `memory[0:MEM_DEPTH-1]` and `register[0:NUM_REGS-1]` for hierarchical preload and inspection. Reset does not clear them.
- Reset clears:
  - PC = 0 and halted = 0.
  - All pipeline latches (IR, NPC, A, B, Imm, ALUOut, LMD, cond, type fields) = 0. IR = 0 decodes as ADD R0,R0,R0, a harmless NOP.
  - The branch-squash flag.
- Instruction format:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
  - imm is sign-extended to 32 bits.
- Opcodes:
  - RR-ALU, writing rd: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed; result 1 or 0), MUL 000101 (low 32 bits).
  - Immediate ALU, writing rt: ADDI 001010, SUBI 001011, SLTI 001100.
  - Load/store: LW 001000 (rt = memory[rs+imm]), SW 001001 (memory[rs+imm] = rt).
  - Branches: BNEQZ 001101 (taken if rs != 0), BEQZ 001110 (taken if rs == 0).
  - HLT 111111.
  - Any other opcode is a NOP.
- Stage functions:
  - IF: IR = memory[PC], NPC = PC+1. PC is a word address.
  - ID: read A = reg[rs] and B = reg[rt], sign-extend imm, classify the instruction type.
  - EX: ALU op, or effective address rs+imm. For branches, target = NPC+imm and cond = (A==0).
  - MEM: LW reads, SW writes.
  - WB: register write, or set halted for HLT.
- Latency: each instruction takes 5 cycles. Instruction i is fetched in cycle i+1 and writes back in cycle i+5.
- Hazards:
  - No forwarding network and no interlocks; software inserts NOPs.
  - Exception: the register file is write-before-read in the same cycle. ID sees the value WB writes in that cycle.
  - Therefore a consumer exactly 3 instructions after its producer sees the new value. A consumer 1 or 2 instructions after sees the old value.
- Register R0 reads as 0 and writes to R0 are ignored.
- Branches:
  - Resolved when the branch is in the EX/MEM latch. On taken, PC = target on that edge.
  - The two younger instructions in IF/ID and ID/EX are squashed to NOP. There are no delay slots.
  - A not-taken branch has no effect.
- HLT:
  - When HLT reaches WB, halted goes to 1.
  - From the next edge, PC, all latches, memory and registers freeze.
  - Instructions younger than HLT never write.
- Reset mid-operation: asynchronous clear as above; execution restarts from PC 0 with current memory contents.
- Addresses are truncated to log2(MEM_DEPTH) bits. PC wraps at MEM_DEPTH.

Test Plan:
- Preload register[k] = k for k = 0..5 and load this program:
  - memory[0..2] = 2801000a, 28010014, 28010019
  - memory[3] = 0ce77800, memory[4] = 0ce77800
  - memory[5] = 00222000, memory[6] = 0ce77800, memory[7] = 00832800
  - memory[12] = fc000000
  - Run 150 cycles.
  - Required: R0=0, R1=25, R2=2, R3=3, R4=27 (write-before-read bypass), R5=7 (R4 stale), R15=7, halted=1.
- LW/SW: memory[120]=85; program LW R2,120(R0); 3 NOPs; ADDI R2,R2,45; 3 NOPs; SW R2,121(R0); HLT -> memory[121] = 130.
- Loop: ADDI R10,R0,5; NOPs; BNEQZ loop that decrements R10 and accumulates R11 += 2 -> R10 = 0, R11 = 10; the two squashed shadow instructions never write.
- MUL/SLT: R1 = -3, R2 = 7 -> MUL gives -21; SLT R3,R1,R2 gives 1; SLTI R4,R2,-1 gives 0.
- Assert rst during the middle of the first program, release it, and rerun -> PC restarts at 0, halted = 0, and the final results match the first scenario.
- Write to R0 (ADDI R0,R0,9) -> register[0] stays 0.

Source files
------------

// File: rtl/pipe_mips32.sv
// pipe_mips32 -- five-stage in-order MIPS32 subset core (IF, ID, EX, MEM, WB).
//
// One word-addressed array `memory` holds both instructions and data. `register`
// is the 32x32 register file. The environment preloads both arrays
// hierarchically. Reset does not clear them. The core runs from PC 0 until a
// HLT instruction retires.
//
// Ports:
//   clk1   : in  - single clock; all state updates on the rising edge
//   rst    : in  - asynchronous active-high reset (PC, latches, halted)
//   halted : out - set when HLT reaches WB; stays high until reset
//
// The core has no forwarding network and no interlocks. The one exception is
// the register file, which is write-before-read: ID sees the value that WB
// writes in the same cycle. Branches resolve when they sit in the EX/MEM latch.
module pipe_mips32 #(
    parameter int MEM_DEPTH = 1024,
    parameter int NUM_REGS  = 32
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    // Type 0 is RR-ALU, so a cleared latch (IR = 0) behaves as ADD R0,R0,R0.
    typedef enum logic [2:0] {
        TY_RR     = 3'd0,
        TY_RM     = 3'd1,
        TY_LOAD   = 3'd2,
        TY_STORE  = 3'd3,
        TY_BRANCH = 3'd4,
        TY_HALT   = 3'd5,
        TY_NOP    = 3'd6
    } itype_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    logic [31:0] memory   [0:MEM_DEPTH-1];
    logic [31:0] register [0:NUM_REGS-1];

    logic [AW-1:0] pc;

    // IF/ID: the full instruction word.
    logic [31:0] if_id_ir, if_id_npc;

    // Past ID, the instruction word is carried as its decoded fields:
    // opcode, type and destination register. A destination of 0 means "no write".
    logic [5:0]  id_ex_op;
    itype_t      id_ex_type;
    logic [4:0]  id_ex_dest;
    logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;

    logic [5:0]  ex_mem_op;
    itype_t      ex_mem_type;
    logic [4:0]  ex_mem_dest;
    logic [31:0] ex_mem_alu_out, ex_mem_b;
    logic        ex_mem_cond;

    itype_t      mem_wb_type;
    logic [4:0]  mem_wb_dest;
    logic [31:0] mem_wb_alu_out, mem_wb_lmd;

    // ---------------- ID: decode and register read ----------------
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm;
    itype_t      id_type;
    logic [4:0]  id_dest;

    assign id_op  = if_id_ir[31:26];
    assign id_rs  = if_id_ir[25:21];
    assign id_rt  = if_id_ir[20:16];
    assign id_rd  = if_id_ir[15:11];
    assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

    always_comb begin
        id_type = TY_NOP;
        id_dest = 5'd0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_type = TY_RR;
                id_dest = id_rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                id_type = TY_RM;
                id_dest = id_rt;
            end
            OP_LW: begin
                id_type = TY_LOAD;
                id_dest = id_rt;
            end
            OP_SW:              id_type = TY_STORE;
            OP_BNEQZ, OP_BEQZ:  id_type = TY_BRANCH;
            OP_HLT:             id_type = TY_HALT;
            default:            id_type = TY_NOP;
        endcase
    end

    // WB write port. Writes to R0 are dropped because dest 0 means "no write".
    logic        wb_we;
    logic [31:0] wb_data;
    assign wb_we   = (mem_wb_dest != 5'd0);
    assign wb_data = (mem_wb_type == TY_LOAD) ? mem_wb_lmd : mem_wb_alu_out;

    // Write-before-read: the value being written this cycle is passed straight to ID.
    logic [31:0] rd_a, rd_b;
    always_comb begin
        rd_a = 32'd0;
        rd_b = 32'd0;
        if (id_rs != 5'd0)
            rd_a = (wb_we && mem_wb_dest == id_rs) ? wb_data : register[id_rs];
        if (id_rt != 5'd0)
            rd_b = (wb_we && mem_wb_dest == id_rt) ? wb_data : register[id_rt];
    end

    // ---------------- EX: ALU / address / branch target ----------------
    logic [31:0] ex_alu;
    always_comb begin
        ex_alu = 32'd0;
        case (id_ex_op)
            OP_ADD:                   ex_alu = id_ex_a + id_ex_b;
            OP_SUB:                   ex_alu = id_ex_a - id_ex_b;
            OP_AND:                   ex_alu = id_ex_a & id_ex_b;
            OP_OR:                    ex_alu = id_ex_a | id_ex_b;
            OP_SLT:                   ex_alu = {31'd0, $signed(id_ex_a) < $signed(id_ex_b)};
            OP_MUL:                   ex_alu = id_ex_a * id_ex_b;
            OP_ADDI, OP_LW, OP_SW:    ex_alu = id_ex_a + id_ex_imm;
            OP_SUBI:                  ex_alu = id_ex_a - id_ex_imm;
            OP_SLTI:                  ex_alu = {31'd0, $signed(id_ex_a) < $signed(id_ex_imm)};
            OP_BNEQZ, OP_BEQZ:        ex_alu = id_ex_npc + id_ex_imm;
            default:                  ex_alu = 32'd0;
        endcase
    end

    // ---------------- Branch resolution and fetch address ----------------
    // ex_mem_cond holds (A == 0). The opcode picks the polarity.
    logic          taken;
    logic [AW-1:0] fetch_addr, fetch_next;
    assign taken = (ex_mem_type == TY_BRANCH) &&
                   ((ex_mem_op == OP_BEQZ) ? ex_mem_cond : !ex_mem_cond);
    // On a taken branch, the fetch on this edge already comes from the target.
    // Only the two instructions already in IF/ID and ID/EX are lost.
    assign fetch_addr = taken ? ex_mem_alu_out[AW-1:0] : pc;
    assign fetch_next = fetch_addr + 1'b1;

    // When HLT is in WB, every latch stops on that edge. This keeps the
    // younger instruction in MEM from storing. The freeze then holds.
    logic freeze;
    assign freeze = halted || (mem_wb_type == TY_HALT);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc             <= '0;
            halted         <= 1'b0;
            if_id_ir       <= 32'd0;
            if_id_npc      <= 32'd0;
            id_ex_op       <= 6'd0;
            id_ex_type     <= TY_RR;
            id_ex_dest     <= 5'd0;
            id_ex_npc      <= 32'd0;
            id_ex_a        <= 32'd0;
            id_ex_b        <= 32'd0;
            id_ex_imm      <= 32'd0;
            ex_mem_op      <= 6'd0;
            ex_mem_type    <= TY_RR;
            ex_mem_dest    <= 5'd0;
            ex_mem_alu_out <= 32'd0;
            ex_mem_b       <= 32'd0;
            ex_mem_cond    <= 1'b0;
            mem_wb_type    <= TY_RR;
            mem_wb_dest    <= 5'd0;
            mem_wb_alu_out <= 32'd0;
            mem_wb_lmd     <= 32'd0;
        end else begin
            if (mem_wb_type == TY_HALT)
                halted <= 1'b1;
            if (!freeze) begin
                // IF
                pc        <= fetch_next;
                if_id_ir  <= memory[fetch_addr];
                if_id_npc <= {{(32-AW){1'b0}}, fetch_next};
                // ID -> ID/EX (squashed to a NOP behind a taken branch)
                id_ex_op   <= taken ? 6'd0  : id_op;
                id_ex_type <= taken ? TY_RR : id_type;
                id_ex_dest <= taken ? 5'd0  : id_dest;
                id_ex_npc  <= if_id_npc;
                id_ex_a    <= rd_a;
                id_ex_b    <= rd_b;
                id_ex_imm  <= id_imm;
                // EX -> EX/MEM (squashed to a NOP behind a taken branch)
                ex_mem_op      <= taken ? 6'd0  : id_ex_op;
                ex_mem_type    <= taken ? TY_RR : id_ex_type;
                ex_mem_dest    <= taken ? 5'd0  : id_ex_dest;
                ex_mem_alu_out <= ex_alu;
                ex_mem_b       <= id_ex_b;
                ex_mem_cond    <= (id_ex_a == 32'd0);
                // MEM -> MEM/WB
                mem_wb_type    <= ex_mem_type;
                mem_wb_dest    <= ex_mem_dest;
                mem_wb_alu_out <= ex_mem_alu_out;
                mem_wb_lmd     <= memory[ex_mem_alu_out[AW-1:0]];
            end
        end
    end

    // Array writes: reset leaves the contents alone.
    always_ff @(posedge clk1) begin
        if (!freeze && ex_mem_type == TY_STORE)
            memory[ex_mem_alu_out[AW-1:0]] <= ex_mem_b;
    end

    always_ff @(posedge clk1) begin
        if (!freeze && wb_we)
            register[mem_wb_dest] <= wb_data;
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32 -- self-checking bench for pipe_mips32.
//
// The model is a timestamped instruction-set interpreter. Instruction n is
// issued at edge f. It reads registers at edge f+1 and sees any write made at
// or before that edge. Memory is accessed at f+3 and registers are written at
// f+4. A taken branch issues its target at f+3. HLT sets halted at edge f+4.
module tb_pipe_mips32;
    localparam int NEVER = 1000000;
    localparam int BIG   = 1000000;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010;
    localparam logic [5:0] OR_ = 6'b000011, SLT = 6'b000100, MUL = 6'b000101;
    localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010;
    localparam logic [5:0] SUBI = 6'b001011, SLTI = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
    localparam logic [31:0] HLT_W = 32'hfc000000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    always #5 clk = ~clk;

    pipe_mips32 dut (
        .clk1   (clk),
        .rst    (rst),
        .halted (halted)
    );

    int total = 0;
    int bad   = 0;

    int edge_n        = 0;
    bit chk_en        = 1'b0;
    int exp_halt_edge = NEVER;

    always @(posedge clk) begin
        if (rst) edge_n = 0;
        else     edge_n = edge_n + 1;
    end

    // ---------------- stimulus images and model state ----------------
    logic [31:0] img  [0:1023];
    logic [31:0] rimg [0:31];
    logic [31:0] m_mem  [0:1023];
    logic [31:0] m_base [0:31];
    logic [31:0] m_reg  [0:31];
    int          m_halt;
    int          wq_t[$];
    int          wq_r[$];
    logic [31:0] wq_v[$];

    logic [31:0] exp_q[$];
    int          lit_r[$];

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle check of the only output against the model's halt edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_h;
            exp_h = (edge_n >= exp_halt_edge);
            total++;
            if (halted !== exp_h) begin
                bad++;
                $display("FAIL halted_cyc edge=%0d: actual=%b required=%b", edge_n, halted, exp_h);
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // ---------------- model ----------------
    function automatic logic [31:0] m_read(input int r, input int t);
        logic [31:0] v;
        if (r == 0) return 32'd0;
        v = m_base[r];
        foreach (wq_t[i])
            if (wq_t[i] <= t && wq_r[i] == r) v = wq_v[i];
        return v;
    endfunction

    // Runs the program from PC 0, keeping only events at or before edge `cut`.
    task automatic model_run(input int cut);
        logic [9:0]  pc, addr;
        logic [31:0] ir, a, b, imm, val;
        logic [5:0]  op;
        int          f, rs, rt, rd, dest;
        bit          done, tk;
        wq_t.delete();
        wq_r.delete();
        wq_v.delete();
        pc = 10'd0;
        f = 1;
        m_halt = NEVER;
        done = 1'b0;
        for (int step = 0; step < 5000 && !done && f <= cut; step++) begin
            ir  = m_mem[pc];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = m_read(rs, f + 1);
            b   = m_read(rt, f + 1);
            dest = 0;
            val  = 32'd0;
            tk   = 1'b0;
            case (op)
                ADD:  begin val = a + b; dest = rd; end
                SUB:  begin val = a - b; dest = rd; end
                AND_: begin val = a & b; dest = rd; end
                OR_:  begin val = a | b; dest = rd; end
                SLT:  begin val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dest = rd; end
                MUL:  begin val = a * b; dest = rd; end
                ADDI: begin val = a + imm; dest = rt; end
                SUBI: begin val = a - imm; dest = rt; end
                SLTI: begin val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; dest = rt; end
                LW:   begin addr = 10'(a + imm); val = m_mem[addr]; dest = rt; end
                SW:   begin addr = 10'(a + imm); if (f + 3 <= cut) m_mem[addr] = b; end
                BNEQZ: tk = (a != 32'd0);
                BEQZ:  tk = (a == 32'd0);
                6'b111111: begin m_halt = f + 4; done = 1'b1; end
                default: ;
            endcase
            if (dest != 0 && f + 4 <= cut) begin
                wq_t.push_back(f + 4);
                wq_r.push_back(dest);
                wq_v.push_back(val);
            end
            if (tk) begin
                pc = pc + 10'd1 + imm[9:0];
                f  = f + 3;
            end else begin
                pc = pc + 10'd1;
                f  = f + 1;
            end
        end
        for (int r = 0; r < 32; r++) m_reg[r] = m_read(r, cut);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_images();
        for (int i = 0; i < 1024; i++) img[i] = 32'd0;
        for (int r = 0; r < 32; r++) rimg[r] = 32'd0;
    endtask

    // Holds reset and preloads DUT and model from the images.
    task automatic start_reset();
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dut.memory[i] = img[i];
            m_mem[i] = img[i];
        end
        for (int r = 0; r < 32; r++) begin
            dut.register[r] = rimg[r];
            m_base[r] = rimg[r];
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int r = 0; r < 32; r++)
            chk($sformatf("%s_r%0d", tag, r), dut.register[r], m_reg[r]);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic lit(input int r, input logic [31:0] v);
        lit_r.push_back(r);
        exp_q.push_back(v);
    endtask

    task automatic drain_literals(input string tag);
        int r;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            r = lit_r.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("%s_lit_r%0d", tag, r), dut.register[r], e);
        end
    endtask

    task automatic load_prog1();
        clear_images();
        img[0] = 32'h2801000a;
        img[1] = 32'h28010014;
        img[2] = 32'h28010019;
        img[3] = 32'h0ce77800;
        img[4] = 32'h0ce77800;
        img[5] = 32'h00222000;
        img[6] = 32'h0ce77800;
        img[7] = 32'h00832800;
        img[12] = HLT_W;
        for (int r = 0; r < 32; r++) rimg[r] = 32'(r);
    endtask

    task automatic prog1_literals();
        lit(0, 32'd0);  lit(1, 32'd25); lit(2, 32'd2);  lit(3, 32'd3);
        lit(4, 32'd27); lit(5, 32'd7);  lit(15, 32'd7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: hazard program (bypass and stale reads) ----
        load_prog1();
        start_reset();
        model_run(BIG);
        chk("s1_model_halt_edge", m_halt, 32'd17);
        exp_halt_edge = m_halt;
        chk_en = 1'b1;
        release_reset();
        run_cycles(150);
        check_model("s1");
        prog1_literals();
        drain_literals("s1");

        // ---- 2: reset in the middle of the same program, then rerun ----
        load_prog1();
        start_reset();
        model_run(8);
        for (int r = 0; r < 32; r++) m_base[r] = m_reg[r];
        model_run(BIG);
        exp_halt_edge = m_halt;
        release_reset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s2_pc_after_rst", 32'(dut.pc), 32'd0);
        chk("s2_halted_after_rst", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        run_cycles(150);
        check_model("s2");
        prog1_literals();
        drain_literals("s2");

        // ---- 3: LW / SW round trip ----
        clear_images();
        img[120] = 32'd85;
        img[0] = enc_i(LW, 0, 2, 120);
        img[4] = enc_i(ADDI, 2, 2, 45);
        img[8] = enc_i(SW, 0, 2, 121);
        img[9] = HLT_W;
        start_reset();
        model_run(BIG);
        chk("s3_model_halt_edge", m_halt, 32'd14);
        exp_halt_edge = m_halt;
        release_reset();
        run_cycles(100);
        check_model("s3");
        chk("s3_mem121", dut.memory[121], m_mem[121]);
        chk("s3_mem121_lit", dut.memory[121], 32'd130);
        lit(2, 32'd130);
        drain_literals("s3");

        // ---- 4: BNEQZ loop; shadow instructions only run on the exit pass ----
        clear_images();
        img[0]  = enc_i(ADDI, 0, 10, 5);
        img[4]  = enc_i(SUBI, 10, 10, 1);
        img[5]  = enc_i(ADDI, 11, 11, 2);
        img[7]  = enc_i(BNEQZ, 10, 0, -4);
        img[8]  = enc_i(ADDI, 12, 12, 1);
        img[9]  = enc_i(ADDI, 13, 13, 1);
        img[10] = HLT_W;
        start_reset();
        model_run(BIG);
        exp_halt_edge = m_halt;
        release_reset();
        run_cycles(150);
        check_model("s4");
        lit(10, 32'd0); lit(11, 32'd10); lit(12, 32'd1); lit(13, 32'd1);
        drain_literals("s4");

        // ---- 5: MUL / SLT / SLTI, R0 write, taken BEQZ and not-taken BNEQZ ----
        clear_images();
        rimg[1] = 32'hfffffffd;
        rimg[2] = 32'd7;
        img[0]  = enc_r(MUL, 1, 2, 3);
        img[1]  = enc_r(SLT, 1, 2, 4);
        img[2]  = enc_i(SLTI, 2, 5, -1);
        img[3]  = enc_r(SUB, 1, 2, 6);
        img[4]  = enc_r(AND_, 1, 2, 7);
        img[5]  = enc_r(OR_, 1, 2, 8);
        img[6]  = enc_i(SUBI, 2, 9, 10);
        img[7]  = enc_i(ADDI, 0, 0, 9);
        img[8]  = enc_i(BEQZ, 0, 0, 2);
        img[9]  = enc_i(ADDI, 0, 20, 1);
        img[10] = enc_i(ADDI, 0, 21, 1);
        img[11] = enc_i(ADDI, 0, 22, 1);
        img[12] = enc_i(BNEQZ, 0, 0, 5);
        img[13] = enc_i(ADDI, 0, 23, 1);
        img[14] = HLT_W;
        start_reset();
        model_run(BIG);
        exp_halt_edge = m_halt;
        release_reset();
        run_cycles(100);
        check_model("s5");
        lit(3, 32'hffffffeb); lit(4, 32'd1);  lit(5, 32'd0);  lit(6, 32'hfffffff6);
        lit(7, 32'd5);        lit(8, 32'hffffffff); lit(9, 32'hfffffffd);
        lit(0, 32'd0);        lit(20, 32'd0); lit(21, 32'd0); lit(22, 32'd1); lit(23, 32'd1);
        drain_literals("s5");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
